// File: rtl/vga_sync_tracker.sv
// Receive-side sync tracker: recovers pixel position from active-low h_sync/v_sync,
// measures line/frame periods and reports lock or loss of lock against the measured timing.
module vga_sync_tracker #(
  parameter int H_ACTIVE    = 1920,
  parameter int V_ACTIVE    = 1080,
  parameter int H_OFFSET    = 192,
  parameter int V_OFFSET    = 41,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        h_sync,
  input  logic        v_sync,
  output logic [11:0] x_pos,
  output logic [10:0] y_pos,
  output logic        in_display_area,
  output logic        frame_start,
  output logic [11:0] h_total_meas,
  output logic [10:0] v_total_meas,
  output logic        locked,
  output logic        sync_error
);

  typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED} state_t;

  localparam logic [11:0] H_MAX  = 12'hFFF;
  localparam logic [10:0] V_MAX  = 11'h7FF;
  localparam logic [11:0] H_OFF  = 12'(H_OFFSET);
  localparam logic [10:0] V_OFF  = 11'(V_OFFSET);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_FRAMES);

  logic        hs_d1, hs_d2, vs_d1, vs_d2;
  logic [11:0] h_count;
  logic [10:0] v_count;
  logic        v_pend;
  state_t      state;
  logic [11:0] ref_h;
  logic [10:0] ref_v;
  logic [3:0]  match;

  logic        h_edge, v_edge, frame_bnd;
  logic        h_sat, v_sat, timeout;
  logic [11:0] h_meas_new;
  logic [10:0] v_meas_new;
  logic        line_bad, frame_bad;
  logic [11:0] x_next;
  logic [10:0] y_next;
  logic        disp_next;

  assign h_edge    = !hs_d1 && hs_d2;
  assign v_edge    = !vs_d1 && vs_d2;
  assign frame_bnd = h_edge && (v_pend || v_edge);
  assign h_sat     = (h_count == H_MAX);
  assign v_sat     = (v_count == V_MAX);
  assign timeout   = h_sat || v_sat;

  // A saturated counter is not a real period, so the previous measurement is kept and
  // also used for the lock comparisons in that cycle.
  assign h_meas_new = h_sat ? h_total_meas : h_count + 12'd1;
  assign v_meas_new = v_sat ? v_total_meas : v_count + 11'd1;
  assign line_bad   = h_edge && (h_meas_new != ref_h);
  assign frame_bad  = frame_bnd && (line_bad || (v_meas_new != ref_v));

  assign x_next    = h_count - H_OFF;
  assign y_next    = v_count - V_OFF;
  assign disp_next = locked && (x_next < H_ACT) && (y_next < V_ACT);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would make results depend on statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      hs_d1           <= 1'b1;
      hs_d2           <= 1'b1;
      vs_d1           <= 1'b1;
      vs_d2           <= 1'b1;
      h_count         <= '0;
      v_count         <= '0;
      v_pend          <= 1'b0;
      h_total_meas    <= '0;
      v_total_meas    <= '0;
      frame_start     <= 1'b0;
      x_pos           <= '0;
      y_pos           <= '0;
      in_display_area <= 1'b0;
    end else begin
      hs_d1       <= h_sync;
      hs_d2       <= hs_d1;
      vs_d1       <= v_sync;
      vs_d2       <= vs_d1;
      frame_start <= frame_bnd;

      if (h_edge) begin
        h_count      <= '0;
        h_total_meas <= h_meas_new;
      end else if (!h_sat) begin
        h_count <= h_count + 12'd1;
      end

      // v_sync may fall anywhere in a line; the frame restarts on the next hsync.
      if (frame_bnd) begin
        v_count      <= '0;
        v_pend       <= 1'b0;
        v_total_meas <= v_meas_new;
      end else begin
        if (v_edge)            v_pend  <= 1'b1;
        if (h_edge && !v_sat)  v_count <= v_count + 11'd1;
      end

      x_pos           <= x_next;
      y_pos           <= y_next;
      in_display_area <= disp_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= UNLOCKED;
      locked     <= 1'b0;
      sync_error <= 1'b0;
      ref_h      <= '0;
      ref_v      <= '0;
      match      <= '0;
    end else begin
      sync_error <= 1'b0;
      if (timeout) begin
        state  <= UNLOCKED;
        locked <= 1'b0;
        if (state == LOCKED) sync_error <= 1'b1;
      end else begin
        case (state)
          UNLOCKED: begin
            if (frame_bnd) begin
              ref_h <= h_meas_new;
              ref_v <= v_meas_new;
              match <= '0;
              state <= ACQUIRE;
            end
          end
          ACQUIRE: begin
            if (frame_bnd) begin
              if (frame_bad) begin
                ref_h <= h_meas_new;
                ref_v <= v_meas_new;
                match <= '0;
              end else if (match + 4'd1 >= LOCK_N) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                match <= match + 4'd1;
              end
            end else if (line_bad) begin
              ref_h <= h_meas_new;
              match <= '0;
            end
          end
          LOCKED: begin
            if (line_bad || frame_bad) begin
              state      <= UNLOCKED;
              locked     <= 1'b0;
              sync_error <= 1'b1;
            end
          end
          default: begin
            state  <= UNLOCKED;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
